pdm_sequencer: RTL

Sequencer for the PDM output buffer multiplexer: it walks `sample_select` through the PDM buffer at a programmable rate and registers the multiplexed PDM word for the PDM output stage. After an arm/trigger handshake it steps the index once per period. It wraps at a programmable last index and flags every captured sample and every wrap. It sits between the PS-configured register bank and the combinational buffer multiplexer, whose output returns on `pdm_data_in`.

---
 rtl/pdm_sequencer.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/pdm_sequencer.sv
// pdm_sequencer
// Steps the PDM buffer index at a programmable rate once it has been armed
// and triggered. It registers the multiplexed buffer word at the end of each
// index slot. It flags every captured sample and every wrap of the index.
module pdm_sequencer #(
  parameter int PDM_DATA_WIDTH          = 64,
  parameter int PDM_BUFFER_ADRESS_WIDTH = 7,
  parameter int PERIOD_WIDTH            = 32
) (
  input  logic                               aclk,
  input  logic                               reset,
  input  logic                               enable,
  input  logic                               trigger,
  input  logic [PERIOD_WIDTH-1:0]            period,
  input  logic [PDM_BUFFER_ADRESS_WIDTH-1:0] last_index,
  input  logic [PDM_DATA_WIDTH-1:0]          pdm_data_in,
  output logic [PDM_BUFFER_ADRESS_WIDTH-1:0] sample_select,
  output logic [PDM_DATA_WIDTH-1:0]          pdm_data_out,
  output logic                               pdm_valid,
  output logic                               wrap,
  output logic                               armed,
  output logic                               busy,
  output logic [31:0]                        sample_count
);

  localparam int AW = PDM_BUFFER_ADRESS_WIDTH;
  localparam int DW = PDM_DATA_WIDTH;
  localparam int PW = PERIOD_WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_s;
  logic            trigger_q_r;
  logic            trig_edge_s;
  logic            capture_s;
  logic [PW-1:0]   period_eff_s;
  logic [PW-1:0]   count_r;
  logic [PW-1:0]   count_s;
  logic [PW-1:0]   period_sh_r;
  logic [PW-1:0]   period_sh_s;
  logic [AW-1:0]   last_sh_r;
  logic [AW-1:0]   last_sh_s;
  logic [AW-1:0]   select_s;
  logic [DW-1:0]   data_s;
  logic            valid_s;
  logic            wrap_s;
  logic [31:0]     scount_s;

  // Periods below two are clamped to two. The mux always gets a full cycle to settle.
  assign period_eff_s = (period < PW'(2)) ? PW'(2) : period;

  // Only a fresh rising edge of trigger may start a run.
  assign trig_edge_s = trigger & ~trigger_q_r;

  // The last cycle of an index slot closes with a capture.
  assign capture_s = (state_r == RUN) && (count_r == (period_sh_r - PW'(1)));

  // Compute the next state, the slot counter, the index and the capture data.
  always_comb begin
    state_s     = state_r;
    count_s     = count_r;
    period_sh_s = period_sh_r;
    last_sh_s   = last_sh_r;
    select_s    = sample_select;
    data_s      = pdm_data_out;
    valid_s     = 1'b0;
    wrap_s      = 1'b0;
    scount_s    = sample_count;
    case (state_r)
      IDLE: begin
        count_s  = PW'(0);
        select_s = AW'(0);
        if (enable) begin
          state_s = ARMED;
        end else begin
          state_s = IDLE;
        end
      end
      ARMED: begin
        if (!enable) begin
          state_s  = IDLE;
          count_s  = PW'(0);
          select_s = AW'(0);
        end else if (trig_edge_s) begin
          // Run parameters are frozen here. Later register writes wait for the next arm.
          state_s     = RUN;
          period_sh_s = period_eff_s;
          last_sh_s   = last_index;
          count_s     = PW'(0);
          select_s    = AW'(0);
          scount_s    = 32'd0;
        end else begin
          state_s = ARMED;
        end
      end
      RUN: begin
        if (capture_s) begin
          data_s   = pdm_data_in;
          valid_s  = 1'b1;
          scount_s = sample_count + 32'd1;
          count_s  = PW'(0);
          if (sample_select == last_sh_r) begin
            select_s = AW'(0);
            wrap_s   = 1'b1;
          end else begin
            select_s = sample_select + AW'(1);
          end
        end else begin
          count_s = count_r + PW'(1);
        end
        // A disable on a capture cycle keeps that capture. The run then stops.
        if (!enable) begin
          state_s  = IDLE;
          count_s  = PW'(0);
          select_s = AW'(0);
        end else begin
          state_s = RUN;
        end
      end
      default: begin
        state_s  = IDLE;
        count_s  = PW'(0);
        select_s = AW'(0);
      end
    endcase
  end

  // Register the state, the shadows and all outputs. Reset takes priority.
  always_ff @(posedge aclk) begin
    if (reset) begin
      state_r       <= IDLE;
      trigger_q_r   <= 1'b0;
      count_r       <= PW'(0);
      period_sh_r   <= PW'(2);
      last_sh_r     <= AW'(0);
      sample_select <= AW'(0);
      pdm_data_out  <= DW'(0);
      pdm_valid     <= 1'b0;
      wrap          <= 1'b0;
      armed         <= 1'b0;
      busy          <= 1'b0;
      sample_count  <= 32'd0;
    end else begin
      state_r       <= state_s;
      trigger_q_r   <= trigger;
      count_r       <= count_s;
      period_sh_r   <= period_sh_s;
      last_sh_r     <= last_sh_s;
      sample_select <= select_s;
      pdm_data_out  <= data_s;
      pdm_valid     <= valid_s;
      wrap          <= wrap_s;
      armed         <= (state_s == ARMED);
      busy          <= (state_s == RUN);
      sample_count  <= scount_s;
    end
  end

endmodule
